bit_decision_sequencer: RTL and testbench

Per-bit control stage of the SC polar decoder, directly upstream of the partial-sum calculator.
- Accepts the final LLR of each bit from the LLR tree and makes the hard decision, forcing frozen bits to 0.
- Drives the calculator's `state`, `new_bit_data` and `id_counter_value` inputs.
- Walks the NEW_BIT_STORE → READ → CAL_AND_STORE sequence until the calculator reports `partial_sum_sigle_bit_cal_fin`, then requests the next LLR.
- Emits the decoded bit stream and an end-of-frame pulse.

---
 rtl/polar_pkg.sv | 25 ++
 rtl/hard_decision.sv | 14 +
 rtl/bit_decision_sequencer.sv | 134 +++++++++++++
 tb/tb_bit_decision_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/polar_pkg.sv
// Shared encodings for the SC polar decoder control path.
// The bit-decision sequencer and the partial-sum calculator both import this package.
package polar_pkg;

  localparam int DEF_STATE_WIDTH      = 10;
  localparam int DEF_ID_COUNTER_WIDTH = 10;

  // One-hot state codes; 4 and 128+ are deliberately left unused.
  localparam logic [DEF_STATE_WIDTH-1:0] IDLE          = DEF_STATE_WIDTH'(1);
  localparam logic [DEF_STATE_WIDTH-1:0] WAIT_LLR      = DEF_STATE_WIDTH'(2);
  localparam logic [DEF_STATE_WIDTH-1:0] DONE          = DEF_STATE_WIDTH'(8);
  localparam logic [DEF_STATE_WIDTH-1:0] NEW_BIT_STORE = DEF_STATE_WIDTH'(16);
  localparam logic [DEF_STATE_WIDTH-1:0] READ          = DEF_STATE_WIDTH'(32);
  localparam logic [DEF_STATE_WIDTH-1:0] CAL_AND_STORE = DEF_STATE_WIDTH'(64);

  typedef enum logic [DEF_STATE_WIDTH-1:0] {
    ST_IDLE          = IDLE,
    ST_WAIT_LLR      = WAIT_LLR,
    ST_DONE          = DONE,
    ST_NEW_BIT_STORE = NEW_BIT_STORE,
    ST_READ          = READ,
    ST_CAL_AND_STORE = CAL_AND_STORE
  } state_t;

endpackage

// File: rtl/hard_decision.sv
// Hard decision on a final bit LLR: negative LLR decides 1, zero or positive decides 0.
// Frozen bits are forced to 0 regardless of the LLR.
module hard_decision #(
  parameter int LLR_WIDTH = 8
) (
  input  logic signed [LLR_WIDTH-1:0] llr,
  input  logic                        frozen_flag,
  output logic                        hard_bit
);

  // Full signed compare rather than a bare MSB tap so every LLR bit is consumed.
  assign hard_bit = !frozen_flag && ($signed(llr) < $signed({LLR_WIDTH{1'b0}}));

endmodule

// File: rtl/bit_decision_sequencer.sv
// Per-bit control stage ahead of the partial-sum calculator: decides each bit,
// then walks NEW_BIT_STORE -> READ -> CAL_AND_STORE until the calculator reports done.
//
// state         | meaning
// --------------+---------------------------------------------------------
// IDLE          | no frame in progress, waiting for start
// WAIT_LLR      | llr_ready high, waiting for the final LLR of the bit
// NEW_BIT_STORE | decision registered, calculator stores the new bit
// READ          | one cycle for the partial-sum BRAM read latency
// CAL_AND_STORE | calculator updates partial sums; leaves on fin
// DONE          | frame_done pulse after the last bit
module bit_decision_sequencer
  import polar_pkg::*;
#(
  parameter int STATE_WIDTH      = DEF_STATE_WIDTH,
  parameter int ID_COUNTER_WIDTH = DEF_ID_COUNTER_WIDTH,
  parameter int LLR_WIDTH        = 8
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic                        llr_valid,
  input  logic signed [LLR_WIDTH-1:0] llr,
  input  logic                        frozen_flag,
  input  logic                        partial_sum_sigle_bit_cal_fin,
  output logic                        llr_ready,
  output logic [STATE_WIDTH-1:0]      state,
  output logic                        new_bit_data,
  output logic [ID_COUNTER_WIDTH-1:0] id_counter_value,
  output logic                        u_hat_valid,
  output logic                        u_hat_data,
  output logic                        frame_done,
  output logic                        busy
);

  localparam logic [ID_COUNTER_WIDTH-1:0] LAST_ID = '1;

  state_t                      state_q, state_d;
  logic [ID_COUNTER_WIDTH-1:0] id_q, id_d;
  logic                        new_bit_q, new_bit_d;
  logic                        u_hat_valid_q, u_hat_valid_d;
  logic                        u_hat_data_q, u_hat_data_d;
  logic                        frame_done_q, frame_done_d;
  logic                        decision;

  hard_decision #(
    .LLR_WIDTH (LLR_WIDTH)
  ) u_hard_decision (
    .llr         (llr),
    .frozen_flag (frozen_flag),
    .hard_bit    (decision)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      id_q          <= '0;
      new_bit_q     <= 1'b0;
      u_hat_valid_q <= 1'b0;
      u_hat_data_q  <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      id_q          <= id_d;
      new_bit_q     <= new_bit_d;
      u_hat_valid_q <= u_hat_valid_d;
      u_hat_data_q  <= u_hat_data_d;
      frame_done_q  <= frame_done_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    id_d          = id_q;
    new_bit_d     = new_bit_q;
    u_hat_data_d  = u_hat_data_q;
    u_hat_valid_d = 1'b0;
    frame_done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_WAIT_LLR;
          id_d    = '0;
        end
      end
      ST_WAIT_LLR: begin
        if (llr_valid) begin
          state_d       = ST_NEW_BIT_STORE;
          new_bit_d     = decision;
          u_hat_data_d  = decision;
          u_hat_valid_d = 1'b1;
        end
      end
      ST_NEW_BIT_STORE: begin
        // The last bit needs no partial-sum update, so it skips READ/CAL entirely.
        if (id_q == LAST_ID) begin
          state_d      = ST_DONE;
          frame_done_d = 1'b1;
        end else begin
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        state_d = ST_CAL_AND_STORE;
      end
      ST_CAL_AND_STORE: begin
        if (partial_sum_sigle_bit_cal_fin) begin
          state_d = ST_WAIT_LLR;
          id_d    = id_q + ID_COUNTER_WIDTH'(1);
        end else begin
          state_d = ST_READ;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        id_d    = '0;
      end
      default: begin
        state_d = ST_IDLE;
        id_d    = '0;
      end
    endcase
  end

  assign state            = STATE_WIDTH'(state_q);
  assign llr_ready        = (state_q == ST_WAIT_LLR);
  assign busy             = (state_q != ST_IDLE);
  assign new_bit_data     = new_bit_q;
  assign id_counter_value = id_q;
  assign u_hat_valid      = u_hat_valid_q;
  assign u_hat_data       = u_hat_data_q;
  assign frame_done       = frame_done_q;

endmodule

// File: tb/tb_bit_decision_sequencer.sv
// Bench for bit_decision_sequencer with an 8-bit frame; decoded bits are
// checked against a scoreboard filled as each LLR is offered.
module tb_bit_decision_sequencer;

  localparam int N = 8;

  typedef struct {
    int d;
    int id;
  } exp_t;

  logic              clk;
  logic              reset_n;
  logic              start;
  logic              llr_valid;
  logic signed [7:0] llr;
  logic              frozen_flag;
  logic              fin;
  logic              llr_ready;
  logic [9:0]        state;
  logic              new_bit_data;
  logic [2:0]        id_counter_value;
  logic              u_hat_valid;
  logic              u_hat_data;
  logic              frame_done;
  logic              busy;

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_frame_done = 0;
  int   n_uhat = 0;
  int   exp_id = 0;
  exp_t sb[$];

  bit_decision_sequencer #(
    .STATE_WIDTH      (10),
    .ID_COUNTER_WIDTH (3),
    .LLR_WIDTH        (8)
  ) dut (
    .clk                           (clk),
    .reset_n                       (reset_n),
    .start                         (start),
    .llr_valid                     (llr_valid),
    .llr                           (llr),
    .frozen_flag                   (frozen_flag),
    .partial_sum_sigle_bit_cal_fin (fin),
    .llr_ready                     (llr_ready),
    .state                         (state),
    .new_bit_data                  (new_bit_data),
    .id_counter_value              (id_counter_value),
    .u_hat_valid                   (u_hat_valid),
    .u_hat_data                    (u_hat_data),
    .frame_done                    (frame_done),
    .busy                          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int want);
    n_checks++;
    if (obs != want) begin
      n_errors++;
      $display("FAIL %s got %0d want %0d", tag, obs, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (u_hat_valid) begin
      n_uhat++;
      if (sb.size() == 0) begin
        check("sb_unexpected_bit", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("u_hat_data", int'(u_hat_data), e.d);
        check("new_bit_data", int'(new_bit_data), e.d);
        check("bit_id", int'(id_counter_value), e.id);
      end
    end
    if (frame_done) n_frame_done++;
  end

  task automatic start_frame();
    check("idle_before_start", int'(state), 1);
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_state", int'(state), 2);
    check("start_llr_ready", int'(llr_ready), 1);
    check("start_busy", int'(busy), 1);
    check("start_id", int'(id_counter_value), 0);
    exp_id = 0;
  endtask

  // nfin: CAL cycles with fin low before the one with fin high.
  // noise: drive start/fin/llr_valid where they must be ignored.
  task automatic send_bit(input int l, input bit fz, input int nfin, input bit noise);
    int   cyc;
    exp_t e;
    e.d  = fz ? 0 : ((l < 0) ? 1 : 0);
    e.id = exp_id;
    check("wait_state", int'(state), 2);
    check("wait_llr_ready", int'(llr_ready), 1);
    check("wait_id", int'(id_counter_value), exp_id);
    llr         = 8'(l);
    frozen_flag = fz;
    llr_valid   = 1'b1;
    start       = noise;
    sb.push_back(e);
    step();
    cyc         = 1;
    llr_valid   = 1'b0;
    start       = 1'b0;
    frozen_flag = 1'b0;
    fin         = noise;
    check("nbs_state", int'(state), 16);
    check("nbs_llr_ready", int'(llr_ready), 0);
    if (exp_id == N - 1) begin
      fin = 1'b0;
      step();
      check("done_state", int'(state), 8);
      check("done_pulse", int'(frame_done), 1);
      step();
      check("end_idle_state", int'(state), 1);
      check("end_busy", int'(busy), 0);
      check("end_id", int'(id_counter_value), 0);
      check("end_frame_done_low", int'(frame_done), 0);
      exp_id = 0;
      return;
    end
    step();
    cyc++;
    check("read_state", int'(state), 32);
    for (int k = 0; k <= nfin; k++) begin
      fin       = noise;
      llr_valid = noise;
      step();
      cyc++;
      check("cal_state", int'(state), 64);
      llr_valid = 1'b0;
      fin       = (k == nfin);
      step();
      cyc++;
      fin = 1'b0;
      if (k < nfin) begin
        check("read_again_state", int'(state), 32);
        check("id_hold", int'(id_counter_value), exp_id);
      end
    end
    check("loop_exit_state", int'(state), 2);
    check("loop_id_inc", int'(id_counter_value), (exp_id + 1) % N);
    check("loop_cycles", cyc, 4 + 2 * nfin);
    exp_id++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   l;
    reset_n     = 1'b0;
    start       = 1'b0;
    llr_valid   = 1'b0;
    llr         = '0;
    frozen_flag = 1'b0;
    fin         = 1'b0;
    step();
    step();
    check("rst_state", int'(state), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_llr_ready", int'(llr_ready), 0);
    check("rst_id", int'(id_counter_value), 0);
    check("rst_uhat_valid", int'(u_hat_valid), 0);
    check("rst_frame_done", int'(frame_done), 0);
    reset_n = 1'b1;
    step();
    check("idle_hold", int'(state), 1);

    // Full frame with a mix of frozen, zero, boundary and slow-fin bits.
    start_frame();
    send_bit(-5,   1'b1, 0, 1'b0);
    send_bit(-3,   1'b0, 2, 1'b1);
    send_bit(0,    1'b0, 0, 1'b0);
    send_bit(7,    1'b0, 3, 1'b0);
    send_bit(-128, 1'b0, 1, 1'b1);
    send_bit(127,  1'b0, 0, 1'b0);
    send_bit(-1,   1'b1, 0, 1'b1);
    send_bit(-1,   1'b0, 0, 1'b1);
    check("frame1_done_count", n_frame_done, 1);
    check("frame1_uhat_count", n_uhat, 8);
    check("frame1_sb_empty", sb.size(), 0);
    step();
    check("frame1_idle_hold", int'(state), 1);

    // Random bits, then an asynchronous reset while bit 5 is in CAL_AND_STORE.
    start_frame();
    for (int i = 0; i < 5; i++) begin
      l = int'($urandom_range(255)) - 128;
      send_bit(l, 1'($urandom_range(1)), int'($urandom_range(1)), 1'b0);
    end
    e.d  = 1;
    e.id = 5;
    sb.push_back(e);
    llr       = -8'sd20;
    llr_valid = 1'b1;
    step();
    llr_valid = 1'b0;
    check("b5_nbs_state", int'(state), 16);
    step();
    check("b5_read_state", int'(state), 32);
    step();
    check("b5_cal_state", int'(state), 64);
    check("b5_id", int'(id_counter_value), 5);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_state", int'(state), 1);
    check("arst_id", int'(id_counter_value), 0);
    check("arst_new_bit", int'(new_bit_data), 0);
    check("arst_uhat_data", int'(u_hat_data), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_llr_ready", int'(llr_ready), 0);
    step();
    step();
    reset_n = 1'b1;
    step();
    step();
    check("post_rst_idle", int'(state), 1);
    check("post_rst_id", int'(id_counter_value), 0);
    start_frame();
    send_bit(-9, 1'b0, 0, 1'b0);
    check("restart_id", int'(id_counter_value), 1);
    check("final_done_count", n_frame_done, 1);
    step();
    check("final_sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
